// File: rtl/gpr_pkg.sv
// rtl/gpr_pkg.sv - shared integer register file constants and types
package gpr_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/gpr_scoreboard.sv
// rtl/gpr_scoreboard.sv - per-register busy flags: alloc sets, write-back clears, alloc wins
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int NUM_WR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  input  logic [NUM_WR-1:0]        wb_en,
  input  logic [NUM_WR*ADDR_W-1:0] wb_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_nxt;

  // Clear on write-back first, then apply allocation so a same-cycle alloc keeps the bit set.
  always_comb begin
    busy_nxt = busy_q;
    for (int w = 0; w < NUM_WR; w++) begin
      if (wb_en[w] && (wb_addr[w*ADDR_W +: ADDR_W] != ZERO_IDX)) begin
        busy_nxt[wb_addr[w*ADDR_W +: ADDR_W]] = 1'b0;
      end
    end
    if (alloc_en && (alloc_addr != ZERO_IDX)) begin
      busy_nxt[alloc_addr] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  // Busy flop bank; reset drops every pending allocation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_nxt;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/gpr_file_sb.sv
// rtl/gpr_file_sb.sv - register file with busy scoreboard; RF_BYPASS_EN enables wb-to-read forwarding
module gpr_file_sb
  import gpr_pkg::*;
#(
  parameter int ADDR_W = REG_ADDR_W,
  parameter int DATA_W = XLEN,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_RD-1:0]        rd_en,
  input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
  output logic [NUM_RD*DATA_W-1:0] rd_data,
  output logic [NUM_RD-1:0]        rd_ready,
  input  logic [NUM_WR-1:0]        wb_en,
  input  logic [NUM_WR*ADDR_W-1:0] wb_addr,
  input  logic [NUM_WR*DATA_W-1:0] wb_data,
  input  logic                     alloc_en,
  input  logic [ADDR_W-1:0]        alloc_addr,
  output logic [2**ADDR_W-1:0]     busy_vec
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] regs [DEPTH];

  gpr_scoreboard #(
    .ADDR_W (ADDR_W),
    .NUM_WR (NUM_WR)
  ) u_scoreboard (
    .clk        (clk),
    .rst        (rst),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .busy_vec   (busy_vec)
  );

  // Write-back merge: ports applied in ascending order so the highest port wins a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int w = 0; w < NUM_WR; w++) begin
        if (wb_en[w] && (wb_addr[w*ADDR_W +: ADDR_W] != ZERO_IDX)) begin
          regs[wb_addr[w*ADDR_W +: ADDR_W]] <= wb_data[w*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Combinational read ports; index 0 and disabled ports return zero and are always ready.
  always_comb begin
    logic [ADDR_W-1:0] idx;
    rd_data  = '0;
    rd_ready = '1;
    for (int p = 0; p < NUM_RD; p++) begin
      idx = rd_addr[p*ADDR_W +: ADDR_W];
      if (rd_en[p] && (idx != ZERO_IDX)) begin
        rd_data[p*DATA_W +: DATA_W] = regs[idx];
        rd_ready[p]                 = ~busy_vec[idx];
`ifdef RF_BYPASS_EN
        for (int w = 0; w < NUM_WR; w++) begin
          if (wb_en[w] && (wb_addr[w*ADDR_W +: ADDR_W] == idx)) begin
            rd_data[p*DATA_W +: DATA_W] = wb_data[w*DATA_W +: DATA_W];
            rd_ready[p]                 = 1'b1;
          end
        end
`else
        // Without forwarding the reader sees the stale value and stalls until the write lands.
`endif
      end
    end
  end

endmodule

// File: tb/tb_gpr_file_sb.sv
// tb/tb_gpr_file_sb.sv - directed and random checks of gpr_file_sb against a reference model
module tb_gpr_file_sb;
  import gpr_pkg::*;

  localparam int AW    = REG_ADDR_W;
  localparam int DW    = XLEN;
  localparam int NR    = 2;
  localparam int NW    = 2;
  localparam int DEPTH = 1 << AW;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NR-1:0]     rd_en;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR*DW-1:0]  rd_data;
  logic [NR-1:0]     rd_ready;
  logic [NW-1:0]     wb_en;
  logic [NW*AW-1:0]  wb_addr;
  logic [NW*DW-1:0]  wb_data;
  logic              alloc_en;
  reg_idx_t          alloc_addr;
  logic [DEPTH-1:0]  busy_vec;

  xlen_t m_reg  [DEPTH];
  bit    m_busy [DEPTH];
  int    checks = 0;
  int    errors = 0;

  gpr_file_sb #(.ADDR_W(AW), .DATA_W(DW), .NUM_RD(NR), .NUM_WR(NW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .wb_en      (wb_en),
    .wb_addr    (wb_addr),
    .wb_data    (wb_data),
    .alloc_en   (alloc_en),
    .alloc_addr (alloc_addr),
    .busy_vec   (busy_vec)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_reg[i]  = '0;
      m_busy[i] = 1'b0;
    end
  endtask

  // Architectural effect of one clock edge with the inputs currently applied.
  task automatic model_edge();
    int a;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int w = 0; w < NW; w++) begin
      a = int'(wb_addr[w*AW +: AW]);
      if (wb_en[w] && a != 0) begin
        m_reg[a]  = wb_data[w*DW +: DW];
        m_busy[a] = 1'b0;
      end
    end
    if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
  endtask

  function automatic xlen_t exp_data(int p);
    int    a = int'(rd_addr[p*AW +: AW]);
    xlen_t r;
    if (!rd_en[p] || a == 0) return '0;
    r = m_reg[a];
`ifdef RF_BYPASS_EN
    for (int w = 0; w < NW; w++)
      if (wb_en[w] && int'(wb_addr[w*AW +: AW]) == a) r = wb_data[w*DW +: DW];
`endif
    return r;
  endfunction

  function automatic logic exp_ready(int p);
    int   a = int'(rd_addr[p*AW +: AW]);
    logic r;
    if (!rd_en[p] || a == 0) return 1'b1;
    r = ~m_busy[a];
`ifdef RF_BYPASS_EN
    for (int w = 0; w < NW; w++)
      if (wb_en[w] && int'(wb_addr[w*AW +: AW]) == a) r = 1'b1;
`endif
    return r;
  endfunction

  function automatic logic [DEPTH-1:0] exp_busy();
    logic [DEPTH-1:0] v = '0;
    for (int i = 1; i < DEPTH; i++) v[i] = m_busy[i];
    return v;
  endfunction

  task automatic check_val(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    for (int p = 0; p < NR; p++) begin
      check_val($sformatf("%s rd_data[%0d]", tag, p), 64'(rd_data[p*DW +: DW]), 64'(exp_data(p)));
      check_val($sformatf("%s rd_ready[%0d]", tag, p), 64'(rd_ready[p]), 64'(exp_ready(p)));
    end
    check_val({tag, " busy_vec"}, 64'(busy_vec), 64'(exp_busy()));
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    rd_en = '0; rd_addr = '0; wb_en = '0; wb_addr = '0; wb_data = '0;
    alloc_en = 1'b0; alloc_addr = '0;
  endtask

  task automatic set_rd(int p, logic en, int a);
    rd_en[p] = en;
    rd_addr[p*AW +: AW] = AW'(a);
  endtask

  task automatic set_wb(int w, logic en, int a, xlen_t d);
    wb_en[w] = en;
    wb_addr[w*AW +: AW] = AW'(a);
    wb_data[w*DW +: DW] = d;
  endtask

  initial begin
    idle();
    model_reset();
    #12;
    // 1: reset state
    set_rd(0, 1, 5); set_rd(1, 1, 0);
    #1 check_all("reset");
    check_val("reset busy_vec const", 64'(busy_vec), 64'd0);
    rst = 1'b1;
    tick();

    // 2: write idx 3, then read it; write to idx 0 is dropped
    idle(); set_wb(0, 1, 3, 32'hDEADBEEF);
    tick();
    idle(); set_rd(0, 1, 3); set_wb(0, 1, 0, 32'h1234);
    #1 check_all("wb3 read");
    check_val("wb3 const", 64'(rd_data[DW-1:0]), 64'hDEADBEEF);
    tick();
    idle(); set_rd(0, 1, 0); set_rd(1, 1, 3);
    #1 check_all("wb0 ignored");
    check_val("wb0 const", 64'(rd_data[DW-1:0]), 64'd0);
    tick();

    // 3: alloc 7 -> busy; write-back 7 clears it
    idle(); alloc_en = 1'b1; alloc_addr = reg_idx_t'(7);
    tick();
    idle(); set_rd(0, 1, 7);
    #1 check_all("alloc7");
    check_val("alloc7 ready const", 64'(rd_ready[0]), 64'd0);
    tick();
    idle(); set_wb(0, 1, 7, 32'h55);
    tick();
    idle(); set_rd(1, 1, 7);
    #1 check_all("wb7 cleared");
    check_val("wb7 data const", 64'(rd_data[2*DW-1:DW]), 64'h55);
    tick();

    // 4: alloc and wb same index -> stays busy; two wb ports same index -> port 1 wins
    idle(); alloc_en = 1'b1; alloc_addr = reg_idx_t'(9); set_wb(0, 1, 9, 32'hA5);
    tick();
    idle(); set_wb(0, 1, 4, 32'h11); set_wb(1, 1, 4, 32'h22);
    #1 check_all("alloc+wb9");
    check_val("busy9 const", 64'(busy_vec[9]), 64'd1);
    tick();
    idle(); set_rd(0, 1, 4); set_rd(1, 1, 9);
    #1 check_all("collision4");
    check_val("collision4 const", 64'(rd_data[DW-1:0]), 64'h22);
    tick();

    // 5: RAW with write-back in flight on the read index
    idle(); alloc_en = 1'b1; alloc_addr = reg_idx_t'(8);
    tick();
    idle(); set_rd(0, 1, 8); set_wb(0, 1, 8, 32'h77);
    #1 check_all("raw8");
`ifdef RF_BYPASS_EN
    check_val("raw8 bypass data", 64'(rd_data[DW-1:0]), 64'h77);
    check_val("raw8 bypass ready", 64'(rd_ready[0]), 64'd1);
`else
    check_val("raw8 stale data", 64'(rd_data[DW-1:0]), 64'd0);
    check_val("raw8 stall ready", 64'(rd_ready[0]), 64'd0);
`endif
    tick();

    // 6: async reset mid-cycle clears scoreboard and array immediately
    idle(); alloc_en = 1'b1; alloc_addr = reg_idx_t'(2);
    tick();
    idle(); set_rd(0, 1, 2); set_rd(1, 1, 4);
    #2 rst = 1'b0; model_reset();
    #1 check_all("async reset");
    check_val("async reset data1", 64'(rd_data[2*DW-1:DW]), 64'd0);
    set_wb(1, 1, 6, 32'hCAFE);
    tick();
    #1 rst = 1'b1;
    idle(); set_rd(0, 1, 2); set_rd(1, 1, 6);
    #1 check_all("post reset");
    check_val("post reset ready2", 64'(rd_ready[0]), 64'd1);
    tick();

    // Random traffic with small index range to provoke collisions
    for (int it = 0; it < 400; it++) begin
      idle();
      for (int p = 0; p < NR; p++) set_rd(p, logic'($urandom_range(0, 1)), int'($urandom_range(0, 11)));
      for (int w = 0; w < NW; w++)
        set_wb(w, logic'($urandom_range(0, 3) == 0), int'($urandom_range(0, 11)), xlen_t'($urandom));
      alloc_en   = logic'($urandom_range(0, 2) == 0);
      alloc_addr = reg_idx_t'($urandom_range(0, 11));
      #1 check_all($sformatf("rand%0d", it));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
